// File: rtl/mips_bus_pkg.sv
// Shared definitions for the single-port memory arbiter of the Harvard core.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        DATA,
        COMMIT
    } arb_state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Sequences fetch, decode, optional data access and commit for the core over one
// Avalon-style memory port; the core is clock-enabled only in the commit cycle.
module mem_port_arbiter
    import mips_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        core_active,
    output logic        core_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic [31:0] bus_readdata,
    input  logic        bus_waitrequest,
    output logic [31:0] stall_count
);

    arb_state_t state;
    arb_state_t next_state;
    logic       instr_accept;
    logic       data_accept;

    assign bus_byteenable = BYTEEN_ALL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A halt committed by the core is only noticed in FETCH, so no read is
    // issued on behalf of an inactive core.
    always_comb begin
        next_state    = state;
        bus_read      = 1'b0;
        bus_write     = 1'b0;
        bus_address   = '0;
        bus_writedata = '0;
        core_enable   = 1'b0;
        instr_accept  = 1'b0;
        data_accept   = 1'b0;
        case (state)
            IDLE: begin
                if (core_active) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (!core_active) begin
                    next_state = IDLE;
                end else begin
                    bus_read    = 1'b1;
                    bus_address = instr_address;
                    if (!bus_waitrequest) begin
                        instr_accept = 1'b1;
                        next_state   = DECODE;
                    end
                end
            end
            DECODE: begin
                next_state = (data_read || data_write) ? DATA : COMMIT;
            end
            DATA: begin
                bus_address = data_address;
                // A simultaneous read and write request performs only the write.
                if (data_write) begin
                    bus_write     = 1'b1;
                    bus_writedata = data_writedata;
                end else begin
                    bus_read = 1'b1;
                end
                if (!bus_waitrequest) begin
                    data_accept = 1'b1;
                    next_state  = COMMIT;
                end
            end
            COMMIT: begin
                core_enable = 1'b1;
                next_state  = FETCH;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_readdata <= '0;
        end else if (instr_accept) begin
            instr_readdata <= bus_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_readdata <= '0;
        end else if (data_accept && !data_write) begin
            data_readdata <= bus_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (core_active && !core_enable) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized instructions checked against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_active;
    logic        core_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;
    logic [31:0] stall_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expStall;
    logic [31:0] expDataRd;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .core_active    (core_active),
        .core_enable    (core_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .bus_address    (bus_address),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_byteenable (bus_byteenable),
        .bus_writedata  (bus_writedata),
        .bus_readdata   (bus_readdata),
        .bus_waitrequest(bus_waitrequest),
        .stall_count    (stall_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one instruction; the memory stalls wf cycles on the fetch and wd on
    // the data access, and the result is compared at transaction level.
    task automatic applyStimulus(input string name, input bit idleFirst, input int wf, input int wd,
                                 input bit rd, input bit wr, input logic [31:0] iaddr,
                                 input logic [31:0] daddr, input logic [31:0] wdata,
                                 input logic [31:0] iword, input logic [31:0] dword,
                                 input bit activeAfter);
        int          cycles = 0;
        int          waitsLeft = wf;
        int          phase = 0;
        int          nAcc = 0;
        int          hyg = 0;
        int          rdCyc = 0;
        int          wrCyc = 0;
        bit          done = 0;
        bit          acc;
        int          expLat;
        logic [31:0] accAddr [2];
        logic [31:0] accData [2];
        logic        accWr [2];
        logic [31:0] commitInstr = 'x;
        logic [31:0] commitData = 'x;
        acc = rd | wr;
        for (int i = 0; i < 2; i++) begin
            accAddr[i] = 'x;
            accData[i] = 'x;
            accWr[i]   = 1'bx;
        end
        instr_address  = iaddr;
        data_address   = daddr;
        data_read      = rd;
        data_write     = wr;
        data_writedata = wdata;
        core_active    = 1'b1;
        while (!done && cycles < 60) begin
            bus_waitrequest = (waitsLeft > 0);
            bus_readdata    = (waitsLeft > 0) ? $urandom : ((phase == 0) ? iword : dword);
            @(negedge clk);
            cycles++;
            if (bus_byteenable !== 4'hF) hyg++;
            if (bus_read === 1'b1 && bus_write === 1'b1) hyg++;
            if (bus_read === 1'b1 || bus_write === 1'b1) begin
                if (bus_read === 1'b1) rdCyc++;
                if (bus_write === 1'b1) wrCyc++;
                if (phase == 0) begin
                    if (bus_address !== iaddr || bus_write !== 1'b0) hyg++;
                end else begin
                    if (bus_address !== daddr) hyg++;
                    if (wr && (bus_writedata !== wdata || bus_read !== 1'b0)) hyg++;
                    if (!wr && bus_writedata !== 32'd0) hyg++;
                end
                if (bus_waitrequest) begin
                    waitsLeft--;
                end else begin
                    if (nAcc < 2) begin
                        accAddr[nAcc] = bus_address;
                        accWr[nAcc]   = bus_write;
                        accData[nAcc] = bus_writedata;
                    end
                    nAcc++;
                    if (phase == 0) begin
                        phase     = 1;
                        waitsLeft = wd;
                    end
                end
            end else if (bus_address !== 32'd0 || bus_writedata !== 32'd0) begin
                hyg++;
            end
            if (core_enable === 1'b1) begin
                done        = 1;
                commitInstr = instr_readdata;
                commitData  = data_readdata;
            end
            @(posedge clk);
            #1;
        end
        core_active = activeAfter;
        expLat = (idleFirst ? 1 : 0) + wf + 3 + (acc ? wd + 1 : 0);
        expStall = expStall + 32'(expLat - 1);
        if (rd && !wr) expDataRd = dword;
        checkOutput({name, "_latency"}, 32'(cycles), 32'(expLat));
        checkOutput({name, "_accepts"}, 32'(nAcc), acc ? 32'd2 : 32'd1);
        checkOutput({name, "_fetch_addr"}, accAddr[0], iaddr);
        checkOutput({name, "_fetch_is_read"}, {31'd0, accWr[0]}, 32'd0);
        checkOutput({name, "_read_cycles"}, 32'(rdCyc), 32'(wf + 1 + ((acc && !wr) ? wd + 1 : 0)));
        checkOutput({name, "_write_cycles"}, 32'(wrCyc), wr ? 32'(wd + 1) : 32'd0);
        checkOutput({name, "_bus_hygiene"}, 32'(hyg), 32'd0);
        checkOutput({name, "_instr_readdata"}, commitInstr, iword);
        checkOutput({name, "_data_readdata"}, commitData, expDataRd);
        checkOutput({name, "_stall_count"}, stall_count, expStall);
        if (acc) begin
            checkOutput({name, "_data_addr"}, accAddr[1], daddr);
            checkOutput({name, "_data_is_write"}, {31'd0, accWr[1]}, {31'd0, wr});
            if (wr) checkOutput({name, "_writedata"}, accData[1], wdata);
        end
    endtask

    // After a halting commit: one FETCH cycle without a read, then idle with a frozen counter.
    task automatic checkHalt(input string name);
        int strobes = 0;
        int enables = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_read !== 1'b0 || bus_write !== 1'b0) strobes++;
            if (core_enable !== 1'b0) enables++;
        end
        @(posedge clk);
        #1;
        checkOutput({name, "_halt_strobes"}, 32'(strobes), 32'd0);
        checkOutput({name, "_halt_enables"}, 32'(enables), 32'd0);
        checkOutput({name, "_halt_stall_frozen"}, stall_count, expStall);
    endtask

    initial begin
        int  pulses;
        int  seen;
        bit  fetched;
        bit  nextIdle;
        int  kind;
        bit  after;
        reset           = 1'b1;
        core_active     = 1'b0;
        instr_address   = '0;
        data_address    = '0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_writedata  = '0;
        bus_readdata    = '0;
        bus_waitrequest = 1'b0;
        expStall        = '0;
        expDataRd       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_bus_read", {31'd0, bus_read}, 32'd0);
        checkOutput("reset_bus_write", {31'd0, bus_write}, 32'd0);
        checkOutput("reset_core_enable", {31'd0, core_enable}, 32'd0);
        checkOutput("reset_instr_readdata", instr_readdata, 32'd0);
        checkOutput("reset_data_readdata", data_readdata, 32'd0);
        checkOutput("reset_stall_count", stall_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus("fetch_wait", 1, 2, 0, 0, 0, 32'hBFC00000, 32'h0, 32'h0,
                      32'h24020005, 32'h0, 1);
        applyStimulus("load", 0, 0, 0, 1, 0, 32'hBFC00004, 32'h1000, 32'h0,
                      32'h8C220000, 32'hDEADBEEF, 1);
        applyStimulus("store", 0, 0, 1, 0, 1, 32'hBFC00008, 32'h2000, 32'h12345678,
                      32'hAC230000, 32'h0, 1);
        applyStimulus("illegal_rw", 0, 1, 2, 1, 1, 32'hBFC0000C, 32'h3000, 32'hCAFEF00D,
                      32'h00000000, 32'h55AA55AA, 1);
        applyStimulus("halt", 0, 0, 0, 0, 0, 32'hBFC00010, 32'h0, 32'h0,
                      32'h0000000C, 32'h0, 0);
        checkHalt("halt");

        // Reset while a store is stalled in the data phase.
        core_active    = 1'b1;
        instr_address  = 32'hBFC00020;
        data_address   = 32'h4000;
        data_read      = 1'b0;
        data_write     = 1'b1;
        data_writedata = 32'hA5A5A5A5;
        fetched        = 0;
        seen           = 0;
        pulses         = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            bus_waitrequest = fetched;
            bus_readdata    = 32'h11111111;
            @(negedge clk);
            if (core_enable === 1'b1) pulses++;
            if (bus_write === 1'b1) begin
                seen        = 1;
                reset       = 1'b1;
                core_active = 1'b0;
            end else begin
                if (bus_read === 1'b1 && !bus_waitrequest) fetched = 1;
                @(posedge clk);
                #1;
            end
        end
        checkOutput("rst_data_reached", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_bus_write_dropped", {31'd0, bus_write}, 32'd0);
        checkOutput("rst_stall_count", stall_count, 32'd0);
        checkOutput("rst_instr_readdata", instr_readdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (core_enable === 1'b1 || bus_read === 1'b1 || bus_write === 1'b1) pulses++;
        end
        checkOutput("rst_no_commit", 32'(pulses), 32'd0);
        checkOutput("rst_stall_held", stall_count, 32'd0);
        @(posedge clk);
        #1;
        expStall  = '0;
        expDataRd = '0;

        nextIdle = 1;
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 3);
            after = ($urandom_range(0, 5) != 0);
            applyStimulus($sformatf("rand%0d", n), nextIdle, $urandom_range(0, 3), $urandom_range(0, 3),
                          (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                          {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                          $urandom, $urandom, $urandom, after);
            nextIdle = !after;
            if (!after) checkHalt($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
